serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 134 +++++++++++++
 tb/tb_serial_adder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder. A start request in idle latches both
// operands; one sum bit is produced per clock, LSB first, over WIDTH cycles.
// The registered result is published on entry to a one-cycle done state.
//
// Ports:
//   clk       - clock, all state updates on the rising edge
//   rst_n     - asynchronous active-low reset
//   start     - add request, honoured only while idle
//   a, b      - operands, sampled only on the accepting edge
//   busy      - high while bits are being shifted
//   done      - one-cycle pulse, sum/carry_out valid
//   sum       - registered (a + b) mod 2^WIDTH
//   carry_out - registered carry out of bit WIDTH-1
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  // One extra bit beyond the index width so the counter never wraps.
  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             carry_q, carry_d;

  logic sum_bit, c_next, last_bit;

  assign sum_bit  = a_sr_q[0] ^ b_sr_q[0] ^ c_q;
  assign c_next   = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & c_q) | (b_sr_q[0] & c_q);
  assign last_bit = (cnt_q == CntW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StShift;
      StShift: if (last_bit) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == StShift);
    done = (state_q == StDone);
  end

  assign sum       = sum_q;
  assign carry_out = carry_q;

  // Datapath next-state
  always_comb begin
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    acc_d   = acc_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_sr_d = a;
          b_sr_d = b;
          acc_d  = '0;
          c_d    = 1'b0;
          cnt_d  = '0;
        end
      end
      StShift: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        // LSB-first accumulation: after WIDTH shifts bit 0 sits at the LSB.
        acc_d  = {sum_bit, acc_q[WIDTH-1:1]};
        c_d    = c_next;
        cnt_d  = cnt_q + CntW'(1);
        if (last_bit) begin
          sum_d   = {sum_bit, acc_q[WIDTH-1:1]};
          carry_d = c_next;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      acc_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8). Inputs change on the falling
// edge; outputs are sampled on the falling edge, away from the active edge.
module tb_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       carry_out;

  int vectors;
  int miscompares;

  serial_adder #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
    vectors++;
    if (sum !== 8'h00) begin miscompares++; $display("FAIL reset_sum got %h want 00", sum); end
    vectors++;
    if (carry_out !== 1'b0) begin
      miscompares++; $display("FAIL reset_carry got %b want 0", carry_out);
    end
    rst_n = 1'b1;
  endtask

  // One addition. Operands are scrambled right after the accepting edge;
  // optionally start is re-pulsed with other operands mid-shift.
  task automatic run_add(input logic [7:0] ta, input logic [7:0] tb_v, input logic [7:0] es,
                         input logic ec, input bit repulse, input string tag);
    int busy_cnt;
    int lat;
    bit seen;
    bit overlap;
    busy_cnt = 0;
    lat      = 0;
    seen     = 1'b0;
    overlap  = 1'b0;
    @(negedge clk);
    a     = ta;
    b     = tb_v;
    start = 1'b1;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 1) begin
        a = ~ta;
        b = ~tb_v;
      end
      if (repulse && i == 3) begin
        start = 1'b1;
        a     = 8'h80;
        b     = 8'h80;
      end
      busy_cnt += int'(busy);
      overlap |= busy & done;
      if (done) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    start = 1'b0;
    vectors++;
    if (!seen) begin miscompares++; $display("FAIL %s_done_seen got 0 want 1", tag); end
    vectors++;
    if (lat != 9) begin miscompares++; $display("FAIL %s_latency got %0d want 9", tag, lat); end
    vectors++;
    if (busy_cnt != 8) begin
      miscompares++; $display("FAIL %s_busy_cycles got %0d want 8", tag, busy_cnt);
    end
    vectors++;
    if (overlap) begin miscompares++; $display("FAIL %s_busy_done_overlap got 1 want 0", tag); end
    vectors++;
    if (sum !== es) begin miscompares++; $display("FAIL %s_sum got %h want %h", tag, sum, es); end
    vectors++;
    if (carry_out !== ec) begin
      miscompares++; $display("FAIL %s_carry got %b want %b", tag, carry_out, ec);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL %s_after_done got busy=%b done=%b want 0 0", tag, busy, done);
    end
  endtask

  task automatic test_basic();
    run_add(8'h0F, 8'h01, 8'h10, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_wrap();
    run_add(8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, "wrap_ff_01");
    run_add(8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0, "wrap_ff_ff");
    run_add(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, "zero");
    run_add(8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0, "alt");
  endtask

  task automatic test_ignore_start();
    int extra;
    extra = 0;
    run_add(8'h01, 8'h01, 8'h02, 1'b0, 1'b1, "ignore_start");
    // Result must hold through idle with no further activity.
    repeat (12) begin
      @(negedge clk);
      extra += int'(done) + int'(busy);
    end
    vectors++;
    if (extra != 0) begin miscompares++; $display("FAIL ignore_extra_op got %0d want 0", extra); end
    vectors++;
    if (sum !== 8'h02) begin miscompares++; $display("FAIL ignore_hold_sum got %h want 02", sum); end
  endtask

  task automatic test_back_to_back();
    int ndone;
    logic [8:0] exp;
    ndone = 0;
    for (int c = 0; c <= 30; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        // Accepted operands were those driven 9 samples earlier.
        exp = {1'b0, 8'((c - 9) * 29 + 3)} + {1'b0, 8'((c - 9) * 71 + 5)};
        vectors++;
        if ((c % 10) != 9) begin
          miscompares++; $display("FAIL b2b_done_cycle got %0d want 9 mod 10", c);
        end
        vectors++;
        if ({carry_out, sum} !== exp) begin
          miscompares++; $display("FAIL b2b_result got %h want %h", {carry_out, sum}, exp);
        end
      end
      a     = 8'(c * 29 + 3);
      b     = 8'(c * 71 + 5);
      start = (c < 30);
    end
    start = 1'b0;
    vectors++;
    if (ndone != 3) begin miscompares++; $display("FAIL b2b_done_count got %0d want 3", ndone); end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int ndone;
    ndone = 0;
    @(negedge clk);
    a     = 8'hAA;
    b     = 8'h55;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy_pre got %b want 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++; $display("FAIL mid_async_ctrl got busy=%b done=%b want 0 0", busy, done);
    end
    vectors++;
    if (sum !== 8'h00 || carry_out !== 1'b0) begin
      miscompares++; $display("FAIL mid_async_result got %b_%h want 0_00", carry_out, sum);
    end
    repeat (3) begin
      @(negedge clk);
      ndone += int'(done);
    end
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      ndone += int'(done) + int'(busy);
    end
    vectors++;
    if (ndone != 0) begin miscompares++; $display("FAIL mid_no_done got %0d want 0", ndone); end
    run_add(8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0, "after_abort");
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_wrap();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
